z_sequencer: RTL and testbench
==============================

Z_SEQUENCER -- requirements
Module: z_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 40, max WAIT_ALU cycles before abort; legal range 1..63.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a Z-result transfer; sampled only in IDLE.
REQ-005 op  input  2  00 ADD (32-bit result), 01 MUL, 10 DIV, 11 reserved; sampled with start.
REQ-006 alu_done  input  1  ALU 64-bit result valid; sampled only in WAIT_ALU.
REQ-007 ready  output  1  high in IDLE only.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 z_in  output  1  load enable to Z register (64-bit capture).
REQ-010 z_low_out  output  1  drive Z low word onto bus.
REQ-011 z_high_out  output  1  drive Z high word onto bus.
REQ-012 dest_in  output  1  general-register write enable (ADD result).
REQ-013 lo_in  output  1  LO register write enable.
REQ-014 hi_in  output  1  HI register write enable.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 error  output  1  one-cycle pulse for reserved op or timeout.

Function
REQ-017 States: IDLE, WAIT_ALU, LOAD_Z, OUT_LOW, OUT_HIGH, DONE; encoded state register plus 2-bit latched op and 6-bit wait counter.
REQ-018 ready, busy, z_in, z_low_out, z_high_out, dest_in, lo_in, hi_in, done: decoded from state and latched op only, no combinational path from inputs.
REQ-019 IDLE: start=1 and op!=11 -> latch op, clear counter, go WAIT_ALU.
REQ-020 IDLE: start=1 and op=11 -> stay IDLE, error=1 in next cycle only.
REQ-021 start while busy: ignored, no effect on latched op or state.
REQ-022 WAIT_ALU: alu_done=1 -> LOAD_Z; else counter increments.
REQ-023 WAIT_ALU: alu_done=0 and counter==TIMEOUT-1 -> IDLE, error=1 next cycle, no z_in issued; WAIT_ALU lasts at most TIMEOUT cycles.
REQ-024 alu_done=1 in the timeout cycle: alu_done wins, go LOAD_Z, no error.
REQ-025 LOAD_Z: z_in=1 for exactly one cycle -> OUT_LOW.
REQ-026 OUT_LOW: z_low_out=1; op ADD -> dest_in=1, next DONE; op MUL/DIV -> lo_in=1, next OUT_HIGH.
REQ-027 OUT_HIGH: z_high_out=1, hi_in=1 -> DONE.
REQ-028 DONE: done=1 for one cycle -> IDLE.
REQ-029 z_low_out and z_high_out never high in the same cycle; dest_in never high with lo_in or hi_in.
REQ-030 Latency, start sampled at edge 0, alu_done high in first WAIT_ALU cycle: ADD done high in cycle 4; MUL/DIV done high in cycle 5.
REQ-031 Back-to-back: start sampled in the IDLE cycle immediately after DONE is accepted (no dead cycle beyond IDLE).

Reset
REQ-032 clr=0 forces state IDLE, counter 0, latched op 00, error 0 immediately, independent of clk.
REQ-033 During reset and first cycle after: ready=1, all other outputs 0.
REQ-034 clr=0 mid-transfer (any state) aborts without done or error; outputs return to reset values asynchronously.

Verification
REQ-035 ADD: start=1, op=00, alu_done=1 at cycle 1 -> z_in cycle 2, z_low_out+dest_in cycle 3, done cycle 4, ready cycle 5.
REQ-036 MUL: op=01, alu_done at cycle 3 -> z_in cycle 4, z_low_out+lo_in cycle 5, z_high_out+hi_in cycle 6, done cycle 7.
REQ-037 Timeout: TIMEOUT=4, op=10, alu_done held 0 -> 4 WAIT_ALU cycles, error pulse, back to IDLE, z_in never asserted.
REQ-038 Reserved op: start=1, op=11 -> error one cycle, busy stays 0; start during MUL OUT_LOW -> ignored, transfer completes normally.
REQ-039 Reset: clr=0 asserted in OUT_HIGH mid-cycle -> z_high_out/hi_in drop before next edge, ready=1, no done pulse.
REQ-040 Boundary: TIMEOUT=4, alu_done=1 exactly in 4th WAIT_ALU cycle -> LOAD_Z, no error.

Source files
------------

// File: rtl/z_sequencer.sv
// Z-result transfer sequencer: waits for the ALU, captures its 64-bit result into Z,
// then moves the low/high words to the general register or to LO/HI.
module z_sequencer #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       alu_done,
  output logic       ready,
  output logic       busy,
  output logic       z_in,
  output logic       z_low_out,
  output logic       z_high_out,
  output logic       dest_in,
  output logic       lo_in,
  output logic       hi_in,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_ALU,
    S_LOAD_Z,
    S_OUT_LOW,
    S_OUT_HIGH,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_RSV    = 2'b11;
  localparam logic [5:0] LAST_WAIT = 6'(TIMEOUT - 1);

  state_t     state, state_next;
  logic [1:0] op_q, op_next;
  logic [5:0] cnt, cnt_next;
  logic       error_q, error_next;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= S_IDLE;
      op_q    <= '0;
      cnt     <= '0;
      error_q <= 1'b0;
    end else begin
      state   <= state_next;
      op_q    <= op_next;
      cnt     <= cnt_next;
      error_q <= error_next;
    end
  end

  // Strobes depend only on state and latched op; error is the only registered pulse.
  always_comb begin
    state_next = state;
    op_next    = op_q;
    cnt_next   = cnt;
    error_next = 1'b0;
    ready      = 1'b0;
    busy       = 1'b0;
    z_in       = 1'b0;
    z_low_out  = 1'b0;
    z_high_out = 1'b0;
    dest_in    = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    done       = 1'b0;

    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (op == OP_RSV) begin
            error_next = 1'b1;
          end else begin
            op_next    = op;
            cnt_next   = '0;
            state_next = S_WAIT_ALU;
          end
        end
      end

      S_WAIT_ALU: begin
        busy = 1'b1;
        if (alu_done) begin
          state_next = S_LOAD_Z;
        end else if (cnt == LAST_WAIT) begin
          error_next = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + 6'd1;
        end
      end

      S_LOAD_Z: begin
        busy       = 1'b1;
        z_in       = 1'b1;
        state_next = S_OUT_LOW;
      end

      S_OUT_LOW: begin
        busy      = 1'b1;
        z_low_out = 1'b1;
        if (op_q == OP_ADD) begin
          dest_in    = 1'b1;
          state_next = S_DONE;
        end else begin
          lo_in      = 1'b1;
          state_next = S_OUT_HIGH;
        end
      end

      S_OUT_HIGH: begin
        busy       = 1'b1;
        z_high_out = 1'b1;
        hi_in      = 1'b1;
        state_next = S_DONE;
      end

      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign error = error_q;

endmodule

// File: tb/tb_z_sequencer.sv
// Directed bench for z_sequencer (TIMEOUT=4): per-cycle output vectors checked
// against hand-computed values for ADD, MUL, timeout, reserved op and reset.
module tb_z_sequencer;

  logic       clk;
  logic       clr;
  logic       start;
  logic [1:0] op;
  logic       alu_done;
  logic       ready, busy, z_in, z_low_out, z_high_out;
  logic       dest_in, lo_in, hi_in, done, error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // {ready,busy,z_in,z_low_out,z_high_out,dest_in,lo_in,hi_in,done,error}
  localparam logic [9:0] V_IDLE  = 10'h200;
  localparam logic [9:0] V_IDLEE = 10'h201;
  localparam logic [9:0] V_WAIT  = 10'h100;
  localparam logic [9:0] V_LOAD  = 10'h180;
  localparam logic [9:0] V_LOWA  = 10'h150;
  localparam logic [9:0] V_LOWM  = 10'h148;
  localparam logic [9:0] V_HIGH  = 10'h124;
  localparam logic [9:0] V_DONE  = 10'h102;

  z_sequencer #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .op         (op),
    .alu_done   (alu_done),
    .ready      (ready),
    .busy       (busy),
    .z_in       (z_in),
    .z_low_out  (z_low_out),
    .z_high_out (z_high_out),
    .dest_in    (dest_in),
    .lo_in      (lo_in),
    .hi_in      (hi_in),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {ready, busy, z_in, z_low_out, z_high_out, dest_in, lo_in, hi_in, done, error};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check the current cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [9:0] exp);
    check(tag, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; op = 2'b00; alu_done = 1'b0;
    #1;
    check("reset_hold", outs(), V_IDLE);
    @(posedge clk);
    #1;
    clr = 1'b1;
    cyc("reset_first", V_IDLE);

    // ADD, alu_done in first WAIT cycle
    start = 1'b1; op = 2'b00;
    cyc("add_c0_idle", V_IDLE);
    start = 1'b0; alu_done = 1'b1;
    cyc("add_c1_wait", V_WAIT);
    alu_done = 1'b0;
    cyc("add_c2_load", V_LOAD);
    cyc("add_c3_low", V_LOWA);
    cyc("add_c4_done", V_DONE);

    // MUL, alu_done in cycle 3, junk start during OUT_LOW
    start = 1'b1; op = 2'b01;
    cyc("mul_c0_idle", V_IDLE);
    start = 1'b0;
    cyc("mul_c1_wait", V_WAIT);
    cyc("mul_c2_wait", V_WAIT);
    alu_done = 1'b1;
    cyc("mul_c3_wait", V_WAIT);
    alu_done = 1'b0;
    cyc("mul_c4_load", V_LOAD);
    start = 1'b1; op = 2'b11;
    cyc("mul_c5_low", V_LOWM);
    start = 1'b0; op = 2'b00;
    cyc("mul_c6_high", V_HIGH);
    cyc("mul_c7_done", V_DONE);

    // Back-to-back ADD started in the IDLE cycle right after DONE
    start = 1'b1; op = 2'b00;
    cyc("b2b_idle", V_IDLE);
    start = 1'b0; alu_done = 1'b1;
    cyc("b2b_wait", V_WAIT);
    alu_done = 1'b0;
    cyc("b2b_load", V_LOAD);
    cyc("b2b_low", V_LOWA);
    cyc("b2b_done", V_DONE);

    // Timeout: DIV with alu_done held low
    start = 1'b1; op = 2'b10;
    cyc("to_idle", V_IDLE);
    start = 1'b0;
    for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), V_WAIT);
    cyc("to_error", V_IDLEE);
    cyc("to_after", V_IDLE);

    // Boundary: alu_done exactly in the 4th WAIT cycle
    start = 1'b1; op = 2'b10;
    cyc("bd_idle", V_IDLE);
    start = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("bd_wait%0d", i), V_WAIT);
    alu_done = 1'b1;
    cyc("bd_wait3", V_WAIT);
    alu_done = 1'b0;
    cyc("bd_load", V_LOAD);
    cyc("bd_low", V_LOWM);
    cyc("bd_high", V_HIGH);
    cyc("bd_done", V_DONE);
    cyc("bd_noerr", V_IDLE);

    // Reserved op
    start = 1'b1; op = 2'b11;
    cyc("rsv_idle", V_IDLE);
    start = 1'b0; op = 2'b00;
    cyc("rsv_error", V_IDLEE);
    cyc("rsv_after", V_IDLE);

    // Asynchronous reset in OUT_HIGH
    start = 1'b1; op = 2'b01;
    cyc("rst_idle", V_IDLE);
    start = 1'b0; alu_done = 1'b1;
    cyc("rst_wait", V_WAIT);
    alu_done = 1'b0;
    cyc("rst_load", V_LOAD);
    cyc("rst_low", V_LOWM);
    check("rst_high", outs(), V_HIGH);
    #2;
    clr = 1'b0;
    #1;
    check("rst_async", outs(), V_IDLE);
    @(posedge clk);
    #1;
    check("rst_held", outs(), V_IDLE);
    clr = 1'b1;
    cyc("rst_rel0", V_IDLE);
    cyc("rst_rel1", V_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
